// File: rtl/mem_cmd_sequencer_pkg.sv
// Shared types for the memory command sequencer: the command word layout
// delivered by the arbiter's command FIFO.
package mem_cmd_sequencer_pkg;

    localparam int CMD_WIDTH = 65;

    // Field order fixes the packed layout: address in the top bits, read flag in bit 0.
    typedef struct packed {
        logic [31:0] address;
        logic [31:0] length;
        logic        read_not_write;
    } memory_command_t;

endpackage

// File: rtl/fifo_sync_sv.sv
// Single-clock FIFO with occupancy count; output word is the current head and
// stays stable until it is popped.
module fifo_sync_sv #(
    parameter int width = 32,
    parameter int depth = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [width-1:0]           i_data,
    input  logic                       i_pop,
    output logic [width-1:0]           o_data,
    output logic                       o_empty,
    output logic [$clog2(depth):0]     o_count
);

    localparam int ptr_w = $clog2(depth);

    logic [width-1:0] r_mem [depth];
    logic [ptr_w-1:0] r_wr_ptr;
    logic [ptr_w-1:0] r_rd_ptr;
    logic [ptr_w:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != (ptr_w+1)'(depth));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ptr_w+1)'(1);
                2'b01:   r_count <= r_count - (ptr_w+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage carries no reset; only pointers and count define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/mem_cmd_sequencer.sv
// Expands arbiter memory commands into per-word memory transactions and
// buffers in-order read returns, issuing reads only against free buffer credit.
module mem_cmd_sequencer
    import mem_cmd_sequencer_pkg::*;
#(
    parameter int mem_width  = 32,
    parameter int addr_width = 28,
    parameter int rd_depth   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [CMD_WIDTH-1:0]  i_mem_cmd_data,
    input  logic                  i_mem_cmd_enable,
    output logic                  o_mem_cmd_ready,
    input  logic [mem_width-1:0]  i_mem_write_data,
    input  logic                  i_mem_write_enable,
    output logic                  o_mem_write_ready,
    output logic [mem_width-1:0]  o_mem_read_data,
    output logic                  o_mem_read_enable,
    input  logic                  i_mem_read_ready,
    output logic                  o_app_cmd_valid,
    input  logic                  i_app_cmd_ready,
    output logic                  o_app_cmd_read,
    output logic [addr_width-1:0] o_app_addr,
    output logic                  o_app_wvalid,
    input  logic                  i_app_wready,
    output logic [mem_width-1:0]  o_app_wdata,
    input  logic                  i_app_rvalid,
    input  logic [mem_width-1:0]  i_app_rdata,
    output logic [31:0]           o_words_written,
    output logic [31:0]           o_words_read,
    output logic                  o_err_unexpected_rdata
);

    localparam int cnt_w = $clog2(rd_depth) + 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    state_t           r_state;
    logic [31:0]      r_addr;
    logic [31:0]      r_remaining;
    logic [cnt_w-1:0] r_outstanding;
    logic [31:0]      r_words_written;
    logic [31:0]      r_words_read;
    logic             r_err;

    memory_command_t  w_cmd;
    logic             w_cmd_fire;
    logic             w_rd_credit;
    logic             w_wr_issue;
    logic             w_rd_issue;
    logic             w_issue;
    logic             w_rv_accept;
    logic             w_rbuf_empty;
    logic [cnt_w-1:0] w_rbuf_count;

    assign w_cmd = memory_command_t'(i_mem_cmd_data);

    // Credit: every issued-but-unreturned read already owns a buffer slot.
    assign w_rd_credit = (32'(r_outstanding) + 32'(w_rbuf_count)) < 32'(rd_depth);

    assign o_mem_cmd_ready   = (r_state == S_IDLE) && !i_reset;
    assign o_mem_write_ready = (r_state == S_WRITE) && i_app_cmd_ready && i_app_wready;
    assign o_app_wvalid      = (r_state == S_WRITE) && i_mem_write_enable;
    assign o_app_cmd_valid   = o_app_wvalid || ((r_state == S_READ) && w_rd_credit);
    assign o_app_cmd_read    = (r_state == S_READ);
    assign o_app_wdata       = (r_state == S_WRITE) ? i_mem_write_data : '0;
    assign o_app_addr        = r_addr[addr_width-1:0];

    assign w_cmd_fire  = o_mem_cmd_ready && i_mem_cmd_enable;
    assign w_wr_issue  = o_app_wvalid && i_app_cmd_ready && i_app_wready;
    assign w_rd_issue  = (r_state == S_READ) && w_rd_credit && i_app_cmd_ready;
    assign w_issue     = w_wr_issue || w_rd_issue;
    assign w_rv_accept = i_app_rvalid && (r_outstanding != '0);

    assign o_mem_read_enable      = !w_rbuf_empty;
    assign o_words_written        = r_words_written;
    assign o_words_read           = r_words_read;
    assign o_err_unexpected_rdata = r_err;

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_outstanding   <= '0;
            r_words_written <= '0;
            r_words_read    <= '0;
            r_err           <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_addr      <= w_cmd.address;
                        r_remaining <= w_cmd.length;
                        if (w_cmd.length == '0)      r_state <= S_DONE;
                        else if (w_cmd.read_not_write) r_state <= S_READ;
                        else                         r_state <= S_WRITE;
                    end
                end
                S_WRITE, S_READ: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + 32'd1;
                        r_remaining <= r_remaining - 32'd1;
                        if (r_remaining == 32'd1) r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            case ({w_rd_issue, w_rv_accept})
                2'b10:   r_outstanding <= r_outstanding + cnt_w'(1);
                2'b01:   r_outstanding <= r_outstanding - cnt_w'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            if (w_wr_issue)                  r_words_written <= r_words_written + 32'd1;
            if (w_rv_accept)                 r_words_read    <= r_words_read + 32'd1;
            if (i_app_rvalid && !w_rv_accept) r_err          <= 1'b1;
        end
    end

    fifo_sync_sv #(
        .width (mem_width),
        .depth (rd_depth)
    ) u_rbuf (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_rv_accept),
        .i_data  (i_app_rdata),
        .i_pop   (o_mem_read_enable && i_mem_read_ready),
        .o_data  (o_mem_read_data),
        .o_empty (w_rbuf_empty),
        .o_count (w_rbuf_count)
    );

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Directed bench for mem_cmd_sequencer with a fixed-latency memory model and
// hand-computed expected addresses, data and counters.
module tb_mem_cmd_sequencer;
    import mem_cmd_sequencer_pkg::*;

    logic                 clk = 1'b0;
    logic                 i_reset = 1'b1;
    logic [CMD_WIDTH-1:0] i_mem_cmd_data = '0;
    logic                 i_mem_cmd_enable = 1'b0;
    logic                 o_mem_cmd_ready;
    logic [31:0]          i_mem_write_data = '0;
    logic                 i_mem_write_enable = 1'b0;
    logic                 o_mem_write_ready;
    logic [31:0]          o_mem_read_data;
    logic                 o_mem_read_enable;
    logic                 i_mem_read_ready = 1'b0;
    logic                 o_app_cmd_valid;
    logic                 i_app_cmd_ready = 1'b1;
    logic                 o_app_cmd_read;
    logic [27:0]          o_app_addr;
    logic                 o_app_wvalid;
    logic                 i_app_wready = 1'b1;
    logic [31:0]          o_app_wdata;
    logic                 i_app_rvalid = 1'b0;
    logic [31:0]          i_app_rdata = '0;
    logic [31:0]          o_words_written;
    logic [31:0]          o_words_read;
    logic                 o_err_unexpected_rdata;

    mem_cmd_sequencer dut (
        .i_clk                  (clk),
        .i_reset                (i_reset),
        .i_mem_cmd_data         (i_mem_cmd_data),
        .i_mem_cmd_enable       (i_mem_cmd_enable),
        .o_mem_cmd_ready        (o_mem_cmd_ready),
        .i_mem_write_data       (i_mem_write_data),
        .i_mem_write_enable     (i_mem_write_enable),
        .o_mem_write_ready      (o_mem_write_ready),
        .o_mem_read_data        (o_mem_read_data),
        .o_mem_read_enable      (o_mem_read_enable),
        .i_mem_read_ready       (i_mem_read_ready),
        .o_app_cmd_valid        (o_app_cmd_valid),
        .i_app_cmd_ready        (i_app_cmd_ready),
        .o_app_cmd_read         (o_app_cmd_read),
        .o_app_addr             (o_app_addr),
        .o_app_wvalid           (o_app_wvalid),
        .i_app_wready           (i_app_wready),
        .o_app_wdata            (o_app_wdata),
        .i_app_rvalid           (i_app_rvalid),
        .i_app_rdata            (i_app_rdata),
        .o_words_written        (o_words_written),
        .o_words_read           (o_words_read),
        .o_err_unexpected_rdata (o_err_unexpected_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model state and bench-side logs
    int          cyc = 0;
    int          rq_due[$];
    logic [31:0] rq_data[$];
    logic        inject_req = 1'b0;
    logic [27:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          rd_issued = 0;
    logic        rd_check_en = 1'b0;
    int          rd_idx = 0;

    // Fixed 10-edge read latency; also injects one stray return on request.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (inject_req) begin
            i_app_rvalid = 1'b1;
            i_app_rdata  = 32'hBAD0_BAD0;
            inject_req   = 1'b0;
        end else if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            i_app_rvalid = 1'b1;
            i_app_rdata  = rq_data.pop_front();
            void'(rq_due.pop_front());
        end else begin
            i_app_rvalid = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!i_reset && o_app_cmd_valid && i_app_cmd_ready) begin
            if (o_app_cmd_read) begin
                rq_due.push_back(cyc + 11);
                rq_data.push_back(32'hD000_0000 | 32'(o_app_addr));
                rd_issued++;
            end else if (o_app_wvalid && i_app_wready) begin
                wr_addr_q.push_back(o_app_addr);
                wr_data_q.push_back(o_app_wdata);
            end
        end
        if (rd_check_en && o_mem_read_enable && i_mem_read_ready) begin
            check("rd_data", o_mem_read_data, 32'hD000_0200 + 32'(rd_idx));
            rd_idx++;
        end
    end

    task automatic send_cmd(input logic [31:0] addr, input logic [31:0] len, input logic rnw);
        memory_command_t c;
        int guard;
        c.address        = addr;
        c.length         = len;
        c.read_not_write = rnw;
        i_mem_cmd_data   = c;
        i_mem_cmd_enable = 1'b1;
        guard = 0;
        #1;
        while (!o_mem_cmd_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("cmd_accept_wait", 64'(guard < 50), 64'd1);
        tick();
        i_mem_cmd_enable = 1'b0;
    endtask

    task automatic run_write(input logic [31:0] addr, input int len, input logic [31:0] base,
                             input int stall_at);
        int guard;
        wr_addr_q.delete();
        wr_data_q.delete();
        i_mem_write_data   = base;
        i_mem_write_enable = 1'b1;
        send_cmd(addr, 32'(len), 1'b0);
        check("wr_first_cycle", o_app_cmd_valid, 64'd1);
        for (int i = 0; i < len; i++) begin
            i_mem_write_data = base + 32'(i);
            if (i == stall_at) begin
                i_app_wready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    check("stall_wr_ready", o_mem_write_ready, 64'd0);
                    tick();
                end
                check("stall_no_issue", 64'(wr_addr_q.size()), 64'(stall_at));
                i_app_wready = 1'b1;
            end
            #1;
            guard = 0;
            while (!o_mem_write_ready && guard < 50) begin
                tick();
                guard++;
            end
            check("wr_wait", 64'(guard < 50), 64'd1);
            tick();
        end
        i_mem_write_enable = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        logic [27:0] wrap_exp [4];

        // Reset values while reset is held
        repeat (3) tick();
        check("rst_cmd_ready", o_mem_cmd_ready, 64'd0);
        check("rst_cmd_valid", o_app_cmd_valid, 64'd0);
        check("rst_addr", o_app_addr, 64'd0);
        check("rst_wr_ready", o_mem_write_ready, 64'd0);
        check("rst_rd_enable", o_mem_read_enable, 64'd0);
        check("rst_err", o_err_unexpected_rdata, 64'd0);
        i_reset = 1'b0;
        #1;
        check("cmd_ready_after_rst", o_mem_cmd_ready, 64'd1);
        tick();

        // Plain 4-word write
        run_write(32'h100, 4, 32'hA0, -1);
        check("wr_count_log", 64'(wr_addr_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check("wr_addr", wr_addr_q[k], 64'h100 + 64'(k));
            check("wr_data", wr_data_q[k], 64'hA0 + 64'(k));
        end
        check("words_written_4", o_words_written, 64'd4);

        // Write with a 3-cycle wready stall before word 2
        run_write(32'h300, 4, 32'hB0, 2);
        check("stall_count_log", 64'(wr_addr_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check("stall_addr", wr_addr_q[k], 64'h300 + 64'(k));
            check("stall_data", wr_data_q[k], 64'hB0 + 64'(k));
        end
        check("words_written_8", o_words_written, 64'd8);

        // Zero-length command: no memory traffic, ready back after DONE
        wr_addr_q.delete();
        send_cmd(32'h500, 32'd0, 1'b0);
        check("zl_cmd_ready_done", o_mem_cmd_ready, 64'd0);
        check("zl_cmd_valid", o_app_cmd_valid, 64'd0);
        tick();
        check("zl_cmd_ready_back", o_mem_cmd_ready, 64'd1);
        check("zl_no_issue", 64'(wr_addr_q.size()), 64'd0);

        // Address wrap at the top of the 28-bit space
        wrap_exp[0] = 28'hFFF_FFFE;
        wrap_exp[1] = 28'hFFF_FFFF;
        wrap_exp[2] = 28'h000_0000;
        wrap_exp[3] = 28'h000_0001;
        run_write(32'h0FFF_FFFE, 4, 32'hC0, -1);
        for (int k = 0; k < 4; k++) check("wrap_addr", wr_addr_q[k], 64'(wrap_exp[k]));
        check("words_written_12", o_words_written, 64'd12);

        // 20-word read against a blocked consumer: credits stop issue at 16
        i_mem_read_ready = 1'b0;
        send_cmd(32'h200, 32'd20, 1'b1);
        repeat (40) tick();
        check("rd_issued_16", 64'(rd_issued), 64'd16);
        check("rd_stalled_valid", o_app_cmd_valid, 64'd0);
        check("rd_words_read_16", o_words_read, 64'd16);
        check("rd_enable_held", o_mem_read_enable, 64'd1);
        repeat (3) tick();
        check("rd_hold_data", o_mem_read_data, 64'hD000_0200);
        rd_idx = 0;
        rd_check_en = 1'b1;
        i_mem_read_ready = 1'b1;
        guard = 0;
        while (rd_idx < 20 && guard < 300) begin
            tick();
            guard++;
        end
        check("rd_drain_wait", 64'(guard < 300), 64'd1);
        check("rd_delivered", 64'(rd_idx), 64'd20);
        check("rd_issued_20", 64'(rd_issued), 64'd20);
        check("rd_words_read_20", o_words_read, 64'd20);
        rd_check_en = 1'b0;
        repeat (2) tick();
        check("rd_buffer_empty", o_mem_read_enable, 64'd0);
        check("rd_cmd_ready", o_mem_cmd_ready, 64'd1);

        // Stray return with nothing outstanding
        check("err_clear", o_err_unexpected_rdata, 64'd0);
        inject_req = 1'b1;
        repeat (3) tick();
        check("err_set", o_err_unexpected_rdata, 64'd1);
        check("err_words_read", o_words_read, 64'd20);
        check("err_dropped", o_mem_read_enable, 64'd0);
        repeat (3) tick();
        check("err_sticky", o_err_unexpected_rdata, 64'd1);

        // Reset in the middle of a 20-word read
        i_mem_read_ready = 1'b0;
        send_cmd(32'h400, 32'd20, 1'b1);
        repeat (4) tick();
        i_reset = 1'b1;
        tick();
        check("mid_rst_cmd_ready", o_mem_cmd_ready, 64'd0);
        check("mid_rst_cmd_valid", o_app_cmd_valid, 64'd0);
        check("mid_rst_cmd_read", o_app_cmd_read, 64'd0);
        check("mid_rst_addr", o_app_addr, 64'd0);
        check("mid_rst_wvalid", o_app_wvalid, 64'd0);
        check("mid_rst_wdata", o_app_wdata, 64'd0);
        check("mid_rst_wr_ready", o_mem_write_ready, 64'd0);
        check("mid_rst_rd_enable", o_mem_read_enable, 64'd0);
        check("mid_rst_written", o_words_written, 64'd0);
        check("mid_rst_read", o_words_read, 64'd0);
        check("mid_rst_err", o_err_unexpected_rdata, 64'd0);
        i_reset = 1'b0;
        #1;
        check("post_rst_cmd_ready", o_mem_cmd_ready, 64'd1);
        repeat (15) tick();
        check("late_rdata_err", o_err_unexpected_rdata, 64'd1);
        check("late_rdata_read", o_words_read, 64'd0);
        check("late_rdata_dropped", o_mem_read_enable, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_cmd_sequencer.md
# mem_cmd_sequencer

Memory-side executor for the FIFO arbiter's command stream: it consumes `MemoryCommand` words and write data in the `cr_mem` domain and drives a single-word memory application interface. Each command is expanded into per-word memory transactions. In-order read data is buffered and returned on `mem_read`. A credit counter ensures read data is never issued without buffer space, because the memory return path has no backpressure.

## Interface
Parameters:
- `mem_width`, 32: data word width; matches the arbiter FIFOs.
- `addr_width`, 28: width of `app_addr`, in words.
- `rd_depth`, 16: return buffer depth, power of two; also the read credit limit.

Ports (one clock; reset is synchronous and active-high):
- `cr_mem.clk`  in  1  clock (ClockReset.client `cr_mem`)
- `cr_mem.reset`  in  1  synchronous active-high reset
- `mem_cmd`  FIFOInterface.in  65  command stream; transfer when `ready && enable`
- `mem_write`  FIFOInterface.in  `mem_width`  write data stream
- `mem_read`  FIFOInterface.out  `mem_width`  read data stream
- `app_cmd_valid`  out  1  memory command valid
- `app_cmd_ready`  in  1  memory accepts a command
- `app_cmd_read`  out  1  1 = read, 0 = write
- `app_addr`  out  `addr_width`  word address
- `app_wvalid`  out  1  write data valid
- `app_wready`  in  1  memory accepts write data
- `app_wdata`  out  `mem_width`  write data
- `app_rvalid`  in  1  read data returned, in order, no backpressure
- `app_rdata`  in  `mem_width`  read data
- `words_written`  out  32  wrapping count of write words issued
- `words_read`  out  32  wrapping count of read words returned
- `err_unexpected_rdata`  out  1  sticky; set when `app_rvalid` arrives with zero reads outstanding

## Operation
- States:
  - IDLE: `mem_cmd.ready` = 1; on transfer, latch address/length/read_not_write and set `issued` = 0.
    - length 0: go to DONE.
    - read_not_write = 1: go to READ.
    - otherwise: go to WRITE.
  - WRITE:
    - `app_cmd_valid` = `app_wvalid` = `mem_write.enable`; `mem_write.ready` = `app_cmd_ready && app_wready`.
    - A word issues only when all three are high. `app_wdata` = `mem_write.data`, `app_cmd_read` = 0.
    - After the last word issues, go to DONE.
  - READ:
    - `app_cmd_valid` = (`outstanding + rbuf_count < rd_depth`); `app_cmd_read` = 1.
    - A word issues on `app_cmd_valid && app_cmd_ready`; `outstanding` increments.
    - After the last word issues, go to DONE. Reads still in flight complete independently.
  - DONE: one cycle, then IDLE.
- `app_addr` = (`address + issued`) truncated to `addr_width`; wraps modulo 2^`addr_width`.
- `outstanding`: `$clog2(rd_depth)+1` bits.
  - Increments on read issue and decrements on `app_rvalid`; both in the same cycle leave it unchanged.
  - It never exceeds `rd_depth`.
- `app_rvalid`:
  - With `outstanding > 0`, the word is pushed into the return buffer; credits guarantee space.
  - With `outstanding == 0`, the word is dropped, `err_unexpected_rdata` is set, and `words_read` does not increment.
- `mem_read` is driven directly from the return buffer output. Its data is held stable while `enable && !ready`.
- Reset mid-operation: state returns to IDLE and the return buffer, `outstanding`, counters and error flag clear. Partially executed commands are abandoned. Late `app_rvalid` words after reset set the error flag.

## Timing
- Reset values:
  - 0: `mem_cmd.ready`, `mem_write.ready`, `mem_read.enable`, all `app_*` valids, `app_addr`, `app_wdata`, `app_cmd_read`, counters, `err_unexpected_rdata`.
  - `mem_cmd.ready` rises the first cycle after reset deasserts.
- A command accepted at edge N can issue its first word in cycle N+1.
- Sustained throughput: 1 word/cycle when the memory and streams are ready.
- Command-to-command gap: 2 cycles (DONE, then IDLE).
- An `app_rvalid` word captured at edge N shows `mem_read.enable` = 1 in cycle N+1.
- Only the ready/valid signals that the state table above defines as combinational are combinational; state, address and counters are registered.

## Structure
- `MemoryCommand` (fields `address[31:0]`, `length[31:0]`, `read_not_write`; 65 bits) stays in `structures.sv`. The state enum is local.
- The return buffer is one `fifo_sync_sv` (width `mem_width`, depth `rd_depth`, `count` output used for credits).

## Test plan
- Write: cmd {addr 0x100, len 4, write}, data 0xA0..0xA3 -> `app_addr` 0x100..0x103 with matching `app_wdata`; `words_written` = 4.
- Write stall: `app_wready` low for 3 cycles mid-burst -> no word issued or lost during the stall; `mem_write.ready` = 0 for those cycles.
- Read: cmd {addr 0x200, len 20, read}, memory latency 10, `mem_read.ready` = 0 -> exactly 16 issued, then stall. Raise ready -> remaining 4 issue. All 20 words delivered in order.
- Zero length: cmd {len 0} -> no `app_cmd_valid`; `mem_cmd.ready` high again 2 cycles later.
- Address wrap: addr 0x0FFFFFFE, len 4 -> `app_addr` 0xFFFFFFE, 0xFFFFFFF, 0x0, 0x1.
- Error and reset: `app_rvalid` with nothing outstanding -> word dropped, error sticky. Reset during a 20-word read -> all outputs return to reset values next cycle.
